spram_stream_ctrl: RTL and testbench
====================================

// Module: spram_stream_ctrl
// PURPOSE
//  Initiator-side controller for the single-port BRAM (spram512x40 / 1024x20 / 2048x10 geometries).
//  Accepts a burst command (base, length, direction) and streams words into the RAM from a
//  valid/ready write stream, or out of it onto a valid/ready read stream.
//  Absorbs the RAM's 1-cycle registered read latency with a 2-entry skid buffer; sits between fabric logic and the BRAM.
// PARAMETERS
//  ADDR_W  9   RAM address width (9/10/11 for the 512x40/1024x20/2048x10 geometries)
//  DATA_W  40  RAM word width (40/20/10)
//  LEN_W   10  burst length width, = ADDR_W+1; a burst covers at most 2**ADDR_W words
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when valid&&ready
//  cmd_write  in   1       1 = write burst, 0 = read burst
//  cmd_base   in   ADDR_W  first word address
//  cmd_len    in   LEN_W   number of words (0 allowed)
//  wr_valid   in   1       write-stream word valid
//  wr_ready   out  1       write-stream ready
//  wr_data    in   DATA_W  write-stream word
//  rd_valid   out  1       read-stream word valid
//  rd_ready   in   1       read-stream consumer ready
//  rd_data    out  DATA_W  read-stream word
//  done       out  1       1-cycle pulse: burst finished
//  err        out  1       qualified by done: burst rejected (address overflow)
//  mem_addr   out  ADDR_W  to RAM addr
//  mem_we     out  1       to RAM we
//  mem_din    out  DATA_W  to RAM datain
//  mem_dout   in   DATA_W  from RAM dataout (valid cycle after address issue)
// BEHAVIOUR
//  - Reset: state IDLE, skid buffer flushed, in-flight read dropped; cmd_ready, wr_ready, rd_valid, done, err,
//    mem_we = 0; mem_addr, mem_din, rd_data = 0. Reset mid-burst aborts silently (no done pulse).
//  - FSM IDLE -> {WRITE | READ} -> [DRAIN] -> DONE -> IDLE.
//  - IDLE: cmd_ready=1 (0 while rst). On accept latch base/len/dir. len=0 -> DONE, err=0, no RAM access.
//    Overflow (base+len > 2**ADDR_W) -> DONE with err=1, no RAM access (see CONFIGURATION).
//  - WRITE: wr_ready=1. Each wr_valid&&wr_ready cycle drives mem_we=1, mem_addr=cur, mem_din=wr_data same cycle
//    (combinational); cur++, remaining--. Last beat -> DONE next cycle. 1 word/cycle max.
//  - READ: issue = mem_addr=cur, mem_we=0. Issue permitted when (buffer entries + in-flight) < 2, or == 2 with a
//    pop (rd_valid&&rd_ready) the same cycle. mem_dout captured into buffer the cycle after issue; rd_valid
//    asserts the following cycle (issue-to-rd_valid latency 2). Sustains 1 word/cycle with rd_ready held high.
//    After last issue -> DRAIN.
//  - DRAIN: no issue; wait until buffer empty and nothing in flight -> DONE.
//  - DONE: done=1 exactly one cycle, err valid that cycle only; -> IDLE. cmd_ready=0 in DONE.
//  - rd_valid/rd_data held stable until popped; never drop or duplicate words; order = address order.
//  - mem_addr holds its last value when idle; mem_we=0 in every state other than a WRITE handshake cycle.
//  - wr_valid outside WRITE and rd_ready outside READ/DRAIN are ignored.
// CONFIGURATION
//  SPRAM_CTRL_WRAP_EN defined: addresses wrap modulo 2**ADDR_W (510,511,0,1,...); overflow check removed, err tied 0.
//  SPRAM_CTRL_WRAP_EN undefined: overflowing command rejected as above, err=1 with done.
// STRUCTURE
//  Package spram_ctrl_pkg: FSM state enum (IDLE/WRITE/READ/DRAIN/DONE); localparams for the three RAM
//  geometries (ADDR_W/DATA_W pairs 9/40, 10/20, 11/10).
//  Sub-module spram_ctrl_skid: 2-entry FIFO with push/pop/count, DATA_W wide, same clk/rst.
// TESTING
//  1. rst high 3 cycles during a READ burst -> all outputs 0, no done; cmd_ready=1 first cycle after release.
//  2. write base=5 len=4 data 0xA,0xB,0xC,0xD, wr_valid held -> mem_we 4 consecutive cycles addr 5..8; done next cycle, err=0.
//  3. read base=5 len=4, rd_ready=1 -> rd_data 0xA..0xD on 4 consecutive cycles, first rd_valid 2 cycles after first issue; done after last pop.
//  4. read len=8 with rd_ready pattern 1,0,1,0,... -> all 8 words in order, no loss/duplication, outstanding never >2.
//  5. ADDR_W=9, base=510 len=4: macro off -> done+err=1, no mem_we/issue; macro on -> addresses 510,511,0,1, err=0.
//  6. cmd_len=0 (write and read) -> done one cycle after accept, err=0, no RAM access.

Source files
------------

// File: rtl/spram_ctrl_pkg.sv
// spram_ctrl_pkg
//   Shared types and constants for the single-port BRAM stream controller.
//   - state_t : controller FSM encoding (IDLE/WRITE/READ/DRAIN/DONE)
//   - GEO_*   : address/data width pairs of the three supported RAM geometries
package spram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 512 x 40
  localparam int GEO512_ADDR_W  = 9;
  localparam int GEO512_DATA_W  = 40;
  // 1024 x 20
  localparam int GEO1024_ADDR_W = 10;
  localparam int GEO1024_DATA_W = 20;
  // 2048 x 10
  localparam int GEO2048_ADDR_W = 11;
  localparam int GEO2048_DATA_W = 10;

endpackage

// File: rtl/spram_ctrl_skid.sv
// spram_ctrl_skid
//   Two-entry FIFO that catches words returning from the RAM's registered read
//   port so the read stream can stall without losing in-flight data.
// Ports
//   clk       in   clock, posedge
//   rst       in   synchronous active-high reset (flushes contents)
//   push      in   write push_data at the tail
//   push_data in   DATA_W word to store
//   pop       in   discard the head entry
//   count     out  number of stored entries (0..2)
//   head      out  oldest stored word (0 after reset)
module spram_ctrl_skid #(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] buf_r [2];
  logic              wptr_r;
  logic              rptr_r;
  logic [1:0]        count_r;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r[0] <= '0;
      buf_r[1] <= '0;
      wptr_r   <= 1'b0;
      rptr_r   <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        buf_r[wptr_r] <= push_data;
        wptr_r        <= ~wptr_r;
      end
      if (pop) begin
        rptr_r <= ~rptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = buf_r[rptr_r];

endmodule

// File: rtl/spram_stream_ctrl.sv
// spram_stream_ctrl
//   Initiator-side burst controller for a single-port BRAM. A command
//   (base, len, direction) streams words from the wr_* stream into the RAM or
//   from the RAM onto the rd_* stream. The RAM's 1-cycle read latency is
//   absorbed by a 2-entry skid buffer, so reads sustain one word per cycle.
// Build option
//   SPRAM_CTRL_WRAP_EN : addresses wrap modulo 2**ADDR_W and err is never set;
//                        undefined, a burst running past the top is rejected
//                        with done+err and no RAM access.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/ready/write/base/len burst command handshake
//   wr_valid/ready/data            write stream (consumed during WRITE)
//   rd_valid/ready/data            read stream (produced during READ/DRAIN)
//   done, err                      1-cycle completion pulse, err qualified by done
//   mem_addr/we/din, mem_dout      RAM port
module spram_stream_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 40,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] cur_r;
  logic [LEN_W-1:0]  rem_r;
  logic              err_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_din_r;

  logic              accept_s;
  logic              wfire_s;
  logic              issue_s;
  logic              pop_s;
  logic              overflow_s;
  logic [1:0]        count_s;
  logic [1:0]        occ_s;
  logic [DATA_W-1:0] head_s;

`ifdef SPRAM_CTRL_WRAP_EN
  assign overflow_s = 1'b0;
`else
  // Burst end compared against the address space size with two spare bits.
  localparam logic [ADDR_W+1:0] SPACE = {2'b01, {ADDR_W{1'b0}}};
  logic [ADDR_W+1:0] end_s;
  assign end_s      = {2'b00, cmd_base} + (ADDR_W+2)'(cmd_len);
  assign overflow_s = (end_s > SPACE);
`endif

  assign accept_s = !rst && (state_r == ST_IDLE) && cmd_valid;
  assign wfire_s  = !rst && (state_r == ST_WRITE) && wr_valid;
  assign pop_s    = !rst && ((state_r == ST_READ) || (state_r == ST_DRAIN))
                    && (count_s != 2'd0) && rd_ready;
  // Buffered plus in-flight words; a pop in the same cycle frees a slot.
  assign occ_s    = count_s + {1'b0, inflight_r};
  assign issue_s  = !rst && (state_r == ST_READ)
                    && ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));

  spram_ctrl_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (mem_dout),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if ((cmd_len == LEN_W'(0)) || overflow_s) begin
            state_nxt_s = ST_DONE;
          end else if (cmd_write) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wfire_s && (rem_r == LEN_W'(1))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (issue_s && (rem_r == LEN_W'(1))) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final buffered word is being popped.
        if (!inflight_r && ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst bookkeeping, read pipeline flag and held RAM-port values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r      <= '0;
      rem_r      <= '0;
      err_r      <= 1'b0;
      inflight_r <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= '0;
    end else begin
      inflight_r <= issue_s;
      if (accept_s) begin
        cur_r <= cmd_base;
        rem_r <= cmd_len;
        err_r <= (cmd_len != LEN_W'(0)) && overflow_s;
      end else if (wfire_s || issue_s) begin
        cur_r      <= cur_r + ADDR_W'(1);
        rem_r      <= rem_r - LEN_W'(1);
        mem_addr_r <= cur_r;
      end
      if (wfire_s) begin
        mem_din_r <= wr_data;
      end
    end
  end

  // Port drive; everything is forced low while reset is asserted.
  always_comb begin
    cmd_ready = !rst && (state_r == ST_IDLE);
    wr_ready  = !rst && (state_r == ST_WRITE);
    rd_valid  = !rst && (count_s != 2'd0);
    done      = !rst && (state_r == ST_DONE);
    err       = !rst && (state_r == ST_DONE) && err_r;
    mem_we    = wfire_s;
    if (rst) begin
      rd_data  = '0;
      mem_addr = '0;
      mem_din  = '0;
    end else begin
      rd_data  = head_s;
      mem_addr = (wfire_s || issue_s) ? cur_r : mem_addr_r;
      mem_din  = wfire_s ? wr_data : mem_din_r;
    end
  end

endmodule

// File: tb/tb_spram_stream_ctrl.sv
module tb_spram_stream_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 40;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic [DATA_W-1:0] ram_m [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;

  spram_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // RAM model with registered read port.
  always @(posedge clk) begin
    if (mem_we) ram_m[mem_addr] <= mem_din;
    mem_dout <= ram_m[mem_addr];
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic w, input int base, input int len);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_base  = ADDR_W'(base);
    cmd_len   = LEN_W'(len);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b expected 1", cmd_ready);
    end
    nxt();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5+ADDR_W+2*DATA_W-1:0] outs;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) nxt();
    rst = 1'b0;
    issue_cmd(1'b0, 0, 8);
    nxt(); nxt();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      outs = {cmd_ready, wr_ready, rd_valid, done, err, mem_we, mem_addr, mem_din, rd_data};
      checks++;
      if (outs !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: outputs=%h expected 0", c, outs);
      end
      nxt();
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rd_valid, done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: cmd_ready,rd_valid,done=%b expected 100", {cmd_ready, rd_valid, done});
    end
    nxt();
    checks++;
    if ({rd_valid, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_inflight_dropped: rd_valid,done=%b expected 00", {rd_valid, done});
    end
  endtask

  task automatic test_write();
    issue_cmd(1'b1, 5, 4);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(40'hA + i);
      #1;
      checks++;
      if ({wr_ready, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, ADDR_W'(5 + i), DATA_W'(40'hA + i)}) begin
        failures++;
        $display("FAIL write_beat%0d: rdy=%b we=%b addr=%0d din=%h expected 1 1 %0d %h",
                 i, wr_ready, mem_we, mem_addr, mem_din, 5 + i, 40'hA + i);
      end
      nxt();
    end
    wr_data = 40'hEE;
    #1;
    checks++;
    if ({done, err, mem_we, wr_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL write_done: done,err,we,wr_ready=%b expected 1000", {done, err, mem_we, wr_ready});
    end
    nxt();
    wr_valid = 1'b0;
    #1;
    checks++;
    if ({done, cmd_ready, mem_addr, mem_din} !== {1'b0, 1'b1, ADDR_W'(8), DATA_W'(40'hD)}) begin
      failures++;
      $display("FAIL write_idle_hold: done=%b cmd_ready=%b addr=%0d din=%h expected 0 1 8 d",
               done, cmd_ready, mem_addr, mem_din);
    end
  endtask

  task automatic test_read();
    int issue_c = -1, first_rv = -1, last_pop = -1, done_c = -1, npop = 0;
    issue_cmd(1'b0, 5, 4);
    rd_ready = 1'b1;
    for (int c = 1; c < 30 && done_c < 0; c++) begin
      #1;
      if (issue_c < 0 && mem_we == 1'b0 && mem_addr == ADDR_W'(5)) issue_c = c;
      if (rd_valid) begin
        checks++;
        if (rd_data !== DATA_W'(40'hA + npop)) begin
          failures++;
          $display("FAIL read_data%0d: got %h expected %h", npop, rd_data, 40'hA + npop);
        end
        if (first_rv < 0) first_rv = c;
        last_pop = c;
        npop++;
      end
      if (done) begin
        done_c = c;
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL read_err: err=%b expected 0", err);
        end
      end
      nxt();
    end
    rd_ready = 1'b0;
    checks++;
    if (done_c < 0) begin
      failures++;
      $display("FAIL read_timeout: done not seen within budget");
    end
    checks++;
    if (issue_c != 1 || first_rv != 3) begin
      failures++;
      $display("FAIL read_latency: issue at %0d rd_valid at %0d expected 1 and 3", issue_c, first_rv);
    end
    checks++;
    if (npop != 4 || last_pop != 6) begin
      failures++;
      $display("FAIL read_stream: pops=%0d last_pop=%0d expected 4 and 6", npop, last_pop);
    end
    checks++;
    if (done_c != 7) begin
      failures++;
      $display("FAIL read_done_cycle: done at %0d expected 7", done_c);
    end
  endtask

  task automatic test_read_throttle();
    int issued = 0, pops = 0;
    logic done_seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    issue_cmd(1'b1, 20, 8);
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = DATA_W'(40'h100 + i);
      nxt();
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL throttle_write_done: done=%b expected 1", done);
    end
    nxt();
    issue_cmd(1'b0, 20, 8);
    for (int c = 1; c < 60 && !done_seen; c++) begin
      rd_ready = c[0];
      #1;
      if (prev_stall) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          failures++;
          $display("FAIL throttle_hold cyc%0d: rd_valid=%b data=%h expected 1 %h", c, rd_valid, rd_data, prev_data);
        end
      end
      if (issued < 8 && mem_we == 1'b0 && mem_addr == ADDR_W'(20 + issued)) issued++;
      if (rd_valid && rd_ready) begin
        checks++;
        if (rd_data !== DATA_W'(40'h100 + pops)) begin
          failures++;
          $display("FAIL throttle_data%0d: got %h expected %h", pops, rd_data, 40'h100 + pops);
        end
        pops++;
      end
      checks++;
      if (issued - pops > 2) begin
        failures++;
        $display("FAIL throttle_outstanding cyc%0d: outstanding=%0d expected <=2", c, issued - pops);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) done_seen = 1'b1;
      nxt();
    end
    rd_ready = 1'b0;
    checks++;
    if (!done_seen || pops != 8 || issued != 8) begin
      failures++;
      $display("FAIL throttle_total: done=%b pops=%0d issued=%0d expected 1 8 8", done_seen, pops, issued);
    end
  endtask

  task automatic test_overflow();
`ifdef SPRAM_CTRL_WRAP_EN
    int exp_a;
    issue_cmd(1'b1, 510, 4);
    for (int i = 0; i < 4; i++) begin
      exp_a = (510 + i) % 512;
      wr_valid = 1'b1;
      wr_data  = DATA_W'(40'h500 + i);
      #1;
      checks++;
      if ({mem_we, mem_addr} !== {1'b1, ADDR_W'(exp_a)}) begin
        failures++;
        $display("FAIL wrap_beat%0d: we=%b addr=%0d expected 1 %0d", i, mem_we, mem_addr, exp_a);
      end
      nxt();
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if ({done, err} !== 2'b10) begin
      failures++;
      $display("FAIL wrap_done: done,err=%b expected 10", {done, err});
    end
    nxt();
`else
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      issue_cmd(k[0] ? 1'b0 : 1'b1, 510, 4);
      #1;
      checks++;
      if ({done, err, mem_we, rd_valid, mem_addr} !== {4'b1100, ADDR_W'(27)}) begin
        failures++;
        $display("FAIL overflow_reject%0d: done,err,we,rv=%b addr=%0d expected 1100 27",
                 k, {done, err, mem_we, rd_valid}, mem_addr);
      end
      nxt();
      #1;
      checks++;
      if ({done, err, mem_we, cmd_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL overflow_after%0d: done,err,we,cmd_ready=%b expected 0001",
                 k, {done, err, mem_we, cmd_ready});
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
    end
    // base 508 len 4 ends exactly at the top: accepted.
    issue_cmd(1'b1, 508, 4);
    wr_valid = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_addr} !== {1'b1, ADDR_W'(508)}) begin
      failures++;
      $display("FAIL overflow_edge: we=%b addr=%0d expected 1 508", mem_we, mem_addr);
    end
    repeat (4) nxt();
    wr_valid = 1'b0;
    #1;
    checks++;
    if ({done, err} !== 2'b10) begin
      failures++;
      $display("FAIL overflow_edge_done: done,err=%b expected 10", {done, err});
    end
    nxt();
`endif
  endtask

  task automatic test_len0();
`ifdef SPRAM_CTRL_WRAP_EN
    localparam int HOLD_A = 1;
`else
    localparam int HOLD_A = 511;
`endif
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      issue_cmd(k[0] ? 1'b0 : 1'b1, 100, 0);
      #1;
      checks++;
      if ({done, err, mem_we, rd_valid, mem_addr} !== {4'b1000, ADDR_W'(HOLD_A)}) begin
        failures++;
        $display("FAIL len0_done%0d: done,err,we,rv=%b addr=%0d expected 1000 %0d",
                 k, {done, err, mem_we, rd_valid}, mem_addr, HOLD_A);
      end
      nxt();
      #1;
      checks++;
      if ({done, mem_we, cmd_ready} !== 3'b001) begin
        failures++;
        $display("FAIL len0_idle%0d: done,we,cmd_ready=%b expected 001", k, {done, mem_we, cmd_ready});
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_throttle();
    test_overflow();
    test_len0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
